// File: rtl/if_stage_if.sv
// Signal bundle between the fetch stage, the PC register, instruction memory and the ID stage.
// master is the fetch stage side; slave is the surrounding pipeline/memory side.
interface if_stage_if;
  logic [31:0] pc;
  logic        pc_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        flush;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;

  modport master (
    input  pc, imem_ready, imem_rdata, id_stall, flush,
    output pc_stall, imem_req, imem_addr, ifid_valid, ifid_instr, ifid_pc4
  );

  modport slave (
    output pc, imem_ready, imem_rdata, id_stall, flush,
    input  pc_stall, imem_req, imem_addr, ifid_valid, ifid_instr, ifid_pc4
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: req/ready fetch from the registered PC into the IF/ID register,
// with a one-entry skid for ID back-pressure and a drain state for flushed requests.
module if_stage #(
  parameter logic [31:0] RESET_PC4 = 32'h0000_0000
) (
  input logic         clk,
  input logic         rst,
  if_stage_if.master  io_bus
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StHold  = 2'd2,
    StDrain = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_ifid_valid;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc4;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc4;
  logic [31:0] r_drain_addr;

  logic        w_accept;
  logic        w_consume;
  logic        w_capture;
  logic [31:0] w_cap_instr;
  logic [31:0] w_cap_pc4;
  logic        w_skid_load;
  logic        w_drain_load;
  logic [31:0] w_pc4;
  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic        w_pc_stall;

  assign w_pc4     = io_bus.pc + 32'd4;
  assign w_accept  = io_bus.imem_ready & ~(r_ifid_valid & io_bus.id_stall);
  assign w_consume = r_ifid_valid & ~io_bus.id_stall;

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_cap_instr  = io_bus.imem_rdata;
    w_cap_pc4    = w_pc4;
    w_skid_load  = 1'b0;
    w_drain_load = 1'b0;
    w_imem_req   = 1'b0;
    w_imem_addr  = io_bus.pc;
    // A flush always lets the PC load the redirect target.
    w_pc_stall   = ~io_bus.flush;

    case (r_state)
      StIdle: begin
        w_state_next = StFetch;
      end
      StFetch: begin
        w_imem_req = 1'b1;
        if (io_bus.flush) begin
          if (!io_bus.imem_ready) begin
            w_drain_load = 1'b1;
            w_state_next = StDrain;
          end
        end else if (w_accept) begin
          w_capture  = 1'b1;
          w_pc_stall = 1'b0;
        end else if (io_bus.imem_ready) begin
          w_skid_load  = 1'b1;
          w_state_next = StHold;
        end
      end
      StHold: begin
        if (io_bus.flush) begin
          w_state_next = StFetch;
        end else if (!io_bus.id_stall) begin
          w_capture    = 1'b1;
          w_cap_instr  = r_skid_instr;
          w_cap_pc4    = r_skid_pc4;
          w_pc_stall   = 1'b0;
          w_state_next = StFetch;
        end
      end
      StDrain: begin
        // Keep presenting the abandoned address until memory completes it.
        w_imem_req  = 1'b1;
        w_imem_addr = r_drain_addr;
        if (io_bus.imem_ready) begin
          w_state_next = StFetch;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Flush outranks a new capture, which outranks a plain consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ifid_valid <= 1'b0;
      r_ifid_instr <= 32'h0000_0000;
      r_ifid_pc4   <= RESET_PC4;
    end else if (io_bus.flush) begin
      r_ifid_valid <= 1'b0;
    end else if (w_capture) begin
      r_ifid_valid <= 1'b1;
      r_ifid_instr <= w_cap_instr;
      r_ifid_pc4   <= w_cap_pc4;
    end else if (w_consume) begin
      r_ifid_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skid_instr <= 32'h0000_0000;
      r_skid_pc4   <= 32'h0000_0000;
      r_drain_addr <= 32'h0000_0000;
    end else begin
      if (w_skid_load) begin
        r_skid_instr <= io_bus.imem_rdata;
        r_skid_pc4   <= w_pc4;
      end
      if (w_drain_load) begin
        r_drain_addr <= io_bus.pc;
      end
    end
  end

  assign io_bus.imem_req   = w_imem_req;
  assign io_bus.imem_addr  = w_imem_addr;
  assign io_bus.pc_stall   = w_pc_stall;
  assign io_bus.ifid_valid = r_ifid_valid;
  assign io_bus.ifid_instr = r_ifid_instr;
  assign io_bus.ifid_pc4   = r_ifid_pc4;

endmodule
